// File: rtl/spi_seq_fsm.sv
// SPI slave sequencer: walks address, R/W flag and data phases and strobes the
// memory/shift-register/MISO enables. Optional burst mode via SPI_SEQ_BURST_EN.
module spi_seq_fsm #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic       cs,
    input  logic       sout,
    output logic       miso_buff,
    output logic       dm_we,
    output logic       addr_we,
    output logic       sr_we,
    output logic       addr_inc,
    output logic       busy,
    output logic       xfer_done,
    output logic [2:0] o_dbg_state
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_WR_DATA   = 3'd2,
        ST_WR_COMMIT = 3'd3,
        ST_RD_LOAD   = 3'd4,
        ST_RD_DATA   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_word_end;

    logic r_miso_buff;
    logic r_dm_we;
    logic r_addr_we;
    logic r_sr_we;
    logic r_busy;
    logic r_xfer_done;

`ifdef SPI_SEQ_BURST_EN
    logic w_burst;
    logic r_addr_inc;
`endif

    // Handshake: cs low qualifies every edge of a transfer; cs high while
    // busy aborts on that edge and suppresses any commit or completion pulse.
    always_comb begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
        w_word_end   = 1'b0;
`ifdef SPI_SEQ_BURST_EN
        w_burst      = 1'b0;
`endif
        if (r_state != ST_IDLE && cs) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = cs ? ST_IDLE : ST_ADDR;
                end
                ST_ADDR: begin
                    if (r_cnt == ADDR_LAST) begin
                        w_next_state = sout ? ST_RD_LOAD : ST_WR_DATA;
                    end else begin
                        w_next_state = ST_ADDR;
                        w_next_cnt   = r_cnt + CNT_ONE;
                    end
                end
                ST_WR_DATA: begin
                    if (r_cnt == DATA_LAST) begin
                        w_next_state = ST_WR_COMMIT;
                    end else begin
                        w_next_state = ST_WR_DATA;
                        w_next_cnt   = r_cnt + CNT_ONE;
                    end
                end
                ST_WR_COMMIT: begin
                    w_word_end = 1'b1;
`ifdef SPI_SEQ_BURST_EN
                    w_next_state = ST_WR_DATA;
                    w_burst      = 1'b1;
`else
                    w_next_state = ST_IDLE;
`endif
                end
                ST_RD_LOAD: begin
                    w_next_state = ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (r_cnt == DATA_LAST) begin
                        w_word_end = 1'b1;
`ifdef SPI_SEQ_BURST_EN
                        w_next_state = ST_RD_LOAD;
                        w_burst      = 1'b1;
`else
                        w_next_state = ST_IDLE;
`endif
                    end else begin
                        w_next_state = ST_RD_DATA;
                        w_next_cnt   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the
    // state register instead of trailing it by a cycle.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_miso_buff <= 1'b0;
            r_dm_we     <= 1'b0;
            r_addr_we   <= 1'b0;
            r_sr_we     <= 1'b0;
            r_busy      <= 1'b0;
            r_xfer_done <= 1'b0;
`ifdef SPI_SEQ_BURST_EN
            r_addr_inc  <= 1'b0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_miso_buff <= (w_next_state == ST_RD_DATA);
            r_dm_we     <= (w_next_state == ST_WR_COMMIT);
            r_addr_we   <= (w_next_state == ST_ADDR);
            r_sr_we     <= (w_next_state == ST_RD_LOAD);
            r_busy      <= (w_next_state != ST_IDLE);
            r_xfer_done <= w_word_end;
`ifdef SPI_SEQ_BURST_EN
            r_addr_inc  <= w_burst;
`endif
        end
    end

    assign miso_buff   = r_miso_buff;
    assign dm_we       = r_dm_we;
    assign addr_we     = r_addr_we;
    assign sr_we       = r_sr_we;
    assign busy        = r_busy;
    assign xfer_done   = r_xfer_done;
    assign o_dbg_state = r_state;
`ifdef SPI_SEQ_BURST_EN
    assign addr_inc    = r_addr_inc;
`else
    assign addr_inc    = 1'b0;
`endif

endmodule

// File: doc/spi_seq_fsm.md
SPI_SEQ_FSM -- requirements
Module: spi_seq_fsm

Interface
REQ-001 Parameter ADDR_W, default 7, number of address bits clocked in before the read/write bit is sampled (legal range 1..32).
REQ-002 Parameter DATA_W, default 8, number of data bits per word (legal range 1..32).
REQ-003 Port sclk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port cs  input  1  chip select, active-low.
REQ-006 Port sout  input  1  shift-register serial bit; read/write flag when sampled (1 = read, 0 = write).
REQ-007 Port miso_buff  output  1  enables the MISO tri-state buffer.
REQ-008 Port dm_we  output  1  data-memory write enable.
REQ-009 Port addr_we  output  1  address-latch write enable.
REQ-010 Port sr_we  output  1  shift-register parallel-load enable.
REQ-011 Port addr_inc  output  1  one-cycle pulse telling the address latch to increment (burst only).
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port xfer_done  output  1  one-cycle pulse when a word completes.

Function
REQ-014 The FSM SHALL have the states IDLE, ADDR, WR_DATA, WR_COMMIT, RD_LOAD and RD_DATA, plus a bit counter cnt sized as clog2(max(ADDR_W,DATA_W))+1.
REQ-015 All outputs SHALL be registered and decoded from the current state: addr_we=1 only in ADDR, dm_we=1 only in WR_COMMIT, sr_we=1 only in RD_LOAD, miso_buff=1 only in RD_DATA.
REQ-016 In IDLE with cs=0 at an edge, the FSM SHALL go to ADDR with cnt=0; with cs=1 it SHALL stay in IDLE.
REQ-017 ADDR SHALL last exactly ADDR_W cycles; at the last edge it SHALL sample sout and go to RD_LOAD if sout=1, or to WR_DATA with cnt=0 if sout=0.
REQ-018 WR_DATA SHALL last exactly DATA_W cycles and then go to WR_COMMIT, which lasts 1 cycle.
REQ-019 RD_LOAD SHALL last 1 cycle and go to RD_DATA with cnt=0; RD_DATA SHALL last exactly DATA_W cycles.
REQ-020 xfer_done SHALL be high for exactly one cycle: the cycle after WR_COMMIT, or the cycle after the last RD_DATA cycle.
REQ-021 At the end of a word (WR_COMMIT or the last RD_DATA cycle), the FSM SHALL go to IDLE, unless burst applies (REQ-027).
REQ-022 Abort: cs=1 at any edge while not in IDLE SHALL force IDLE on that edge; every output SHALL be 0 the next cycle, no dm_we pulse SHALL occur, and xfer_done SHALL stay 0.
REQ-023 When cs=1 on the same edge that WR_COMMIT would be entered, abort SHALL win and dm_we SHALL NOT assert.
REQ-024 An unencoded state value SHALL return to IDLE on the next edge, with all outputs 0.

Reset
REQ-025 While reset=1, the state SHALL be IDLE, cnt=0, and miso_buff, dm_we, addr_we, sr_we, addr_inc, busy and xfer_done SHALL all be 0, independent of sclk.
REQ-026 A reset asserted mid-transfer SHALL discard the transfer; after release, a new transfer SHALL start only on an edge with cs=0.

Configuration
REQ-027 With macro SPI_SEQ_BURST_EN defined, if cs=0 at the end-of-word edge, the FSM SHALL pulse addr_inc for 1 cycle and continue without a new address phase: write goes to WR_DATA (cnt=0), read goes to RD_LOAD; xfer_done still pulses once per word.
REQ-028 Without SPI_SEQ_BURST_EN, addr_inc SHALL be tied to 0 and every word SHALL end in IDLE regardless of cs.

Verification
REQ-029 Defaults, cs low, address 7'h15, sout=0 at the R/W edge, then 8 data bits -> addr_we high 7 cycles, 8 cycles idle outputs, dm_we high 1 cycle, xfer_done 1 cycle later, back in IDLE.
REQ-030 Defaults, sout=1 at the R/W edge -> sr_we high 1 cycle, then miso_buff high exactly 8 cycles, then IDLE with busy=0.
REQ-031 cs raised after 4 write data bits -> IDLE next edge, dm_we never asserted, xfer_done=0.
REQ-032 Reset pulsed asynchronously (between edges) during RD_DATA -> miso_buff and busy go 0 immediately; the next transfer with cs=0 completes normally.
REQ-033 ADDR_W=3, DATA_W=16 with SPI_SEQ_BURST_EN defined, cs held low for 3 write words -> one address phase, 3 dm_we pulses spaced 17 cycles apart, 2 addr_inc pulses.
REQ-034 Same stimulus as REQ-033 without the macro -> 1 dm_we pulse, addr_inc stays 0, and the FSM re-enters ADDR because cs is still low.
